reg_write_queue: RTL

REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/reg_write_queue_match.sv | 30 +++
 rtl/reg_write_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU register encodings and the pending register-write entry.
// reg16_idx maps any write entry onto the 16-bit register it touches.
package cpu_pkg;

  typedef enum logic [2:0] {
    AX = 3'd0, CX = 3'd1, DX = 3'd2, BX = 3'd3,
    SP = 3'd4, BP = 3'd5, SI = 3'd6, DI = 3'd7
  } GPR16_t;

  typedef enum logic [2:0] {
    AL = 3'd0, CL = 3'd1, DL = 3'd2, BL = 3'd3,
    AH = 3'd4, CH = 3'd5, DH = 3'd6, BH = 3'd7
  } GPR8_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic        is_8_bit;
    logic [15:0] val;
  } wr_entry_t;

  // Byte registers AL..BH live inside AX..BX; bit 2 only picks the half.
  function automatic logic [2:0] reg16_idx(input wr_entry_t e);
    return e.is_8_bit ? {1'b0, e.sel[1:0]} : e.sel;
  endfunction

endpackage

// File: rtl/reg_write_queue_match.sv
// Newest-match search over the queued writes, entries supplied oldest first.
// A byte write as newest match reports a conflict instead of a forwardable value.
module reg_write_queue_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wr_entry_t [DEPTH-1:0] ent_by_age,
  input  logic [DEPTH-1:0]      ent_vld,
  input  logic [2:0]            lookup_sel,
  output logic                  lookup_hit,
  output logic                  lookup_conflict,
  output logic [15:0]           lookup_val
);

  always_comb begin
    lookup_hit      = 1'b0;
    lookup_conflict = 1'b0;
    lookup_val      = '0;
    // Later (younger) matches overwrite earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (reg16_idx(ent_by_age[i]) == lookup_sel)) begin
        lookup_hit      = !ent_by_age[i].is_8_bit;
        lookup_conflict = ent_by_age[i].is_8_bit;
        lookup_val      = ent_by_age[i].is_8_bit ? 16'h0000 : ent_by_age[i].val;
      end
    end
  end

endmodule

// File: rtl/reg_write_queue.sv
// FIFO of pending register-file writes, drained one per unstalled cycle from registered state.
// Forwarding of queued values is built only with REG_WRITE_QUEUE_FORWARD_EN defined.
module reg_write_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [2:0]              push_sel,
  input  logic                    push_is_8_bit,
  input  logic [15:0]             push_val,
  input  logic                    flush,
  input  logic                    rf_stall,
  output logic                    rf_wr_en,
  output logic [2:0]              rf_wr_sel,
  output logic [15:0]             rf_wr_val,
  output logic                    rf_is_8_bit,
  input  logic [2:0]              lookup_sel,
  output logic                    lookup_hit,
  output logic [15:0]             lookup_val,
  output logic                    lookup_conflict,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, push_acc, pop;
  wr_entry_t             head;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    // Acceptance looks at pre-pop occupancy, so a full queue refuses even while draining.
    push_acc = push_valid && !full && !flush;
    pop      = !empty && !rf_stall;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        mem_d[wr_ptr_q].sel      = push_sel;
        mem_d[wr_ptr_q].is_8_bit = push_is_8_bit;
        mem_d[wr_ptr_q].val      = push_is_8_bit ? {8'h00, push_val[7:0]} : push_val;
        wr_ptr_d                 = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head        = empty ? '0 : mem_q[rd_ptr_q];
    rf_wr_en    = pop;
    rf_wr_sel   = head.sel;
    rf_wr_val   = head.val;
    rf_is_8_bit = head.is_8_bit;
  end

  assign push_ready = !full;
  assign count      = count_q;

`ifdef REG_WRITE_QUEUE_FORWARD_EN
  wr_entry_t [DEPTH-1:0] ent_by_age;
  logic [DEPTH-1:0]      ent_vld;

  // Rotate storage so index 0 is the head; the entry draining now stays valid.
  always_comb begin
    ent_by_age = '0;
    ent_vld    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_by_age[i] = mem_q[rd_ptr_q + PW'(i)];
      ent_vld[i]    = (CW'(i) < count_q);
    end
  end

  reg_write_queue_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .ent_by_age      (ent_by_age),
    .ent_vld         (ent_vld),
    .lookup_sel      (lookup_sel),
    .lookup_hit      (lookup_hit),
    .lookup_conflict (lookup_conflict),
    .lookup_val      (lookup_val)
  );
`else
  logic unused_lookup_sel;
  assign unused_lookup_sel = ^lookup_sel;

  // Without forwarding, any pending write makes the caller stall.
  assign lookup_hit      = 1'b0;
  assign lookup_conflict = !empty;
  assign lookup_val      = '0;
`endif

endmodule
